// File: rtl/lcd_bus_monitor_pkg.sv
// Shared definitions for the character-LCD bus monitor.
// Holds the receive FSM state type, the HD44780 command encodings the monitor
// decodes, and the init nibbles that lcd_ctrl also drives.
package lcd_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_HI,
        S_LO
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam int unsigned CMD_DDADDR_BIT = 7;
    localparam logic [6:0] DDRAM_WRAP     = 7'h7F;

    localparam logic [3:0] NIB_8BIT = 4'h3;
    localparam logic [3:0] NIB_4BIT = 4'h2;

    // Return-home ignores bit 0, so both 0x02 and 0x03 qualify.
    function automatic logic is_home(input logic [7:0] b);
        return b[7:1] == CMD_HOME[7:1];
    endfunction

endpackage

// File: rtl/lcd_bus_monitor_if.sv
// Pin-level 4-bit character-LCD write bus (SF_D[11:8], LCD_E, LCD_RS, LCD_RW).
// master: the controller driving the pins.  slave: a receiver such as the monitor.
interface lcd_bus_if;

    logic [3:0] lcd_d;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;

    modport master (
        output lcd_d,
        output lcd_e,
        output lcd_rs,
        output lcd_rw
    );

    modport slave (
        input lcd_d,
        input lcd_e,
        input lcd_rs,
        input lcd_rw
    );

endinterface

// File: rtl/lcd_bus_monitor_pin_sync.sv
// Pin front end for the LCD bus monitor.
// Synchronizes the asynchronous LCD pins, detects falling edges of E, and
// measures the E high time.
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   lcd_d/e/rs/rw   raw LCD pins
//   fall_ok         registered pulse: E fell after at least MIN_E_CYCLES high
//   fall_short      registered pulse: E fell after a too-short high time
//   nib, rs, rw     pin values from the last synchronized E-high cycle,
//                   valid alongside fall_ok / fall_short
module lcd_pin_sync #(
    parameter int unsigned MIN_E_CYCLES = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lcd_d,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    output logic       fall_ok,
    output logic       fall_short,
    output logic [3:0] nib,
    output logic       rs,
    output logic       rw
);

    localparam int unsigned CW = $clog2(MIN_E_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_E_CYCLES);

    logic [3:0]    d_s1, d_s2;
    logic          e_s1, e_s2;
    logic          rs_s1, rs_s2;
    logic          rw_s1, rw_s2;
    logic          e_prev;
    logic [3:0]    nib_hold;
    logic          rs_hold;
    logic          rw_hold;
    logic [CW-1:0] e_cnt;
    logic          fall;

    assign fall = e_prev & ~e_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_s1       <= '0;
            d_s2       <= '0;
            e_s1       <= 1'b0;
            e_s2       <= 1'b0;
            rs_s1      <= 1'b0;
            rs_s2      <= 1'b0;
            rw_s1      <= 1'b0;
            rw_s2      <= 1'b0;
            e_prev     <= 1'b0;
            nib_hold   <= '0;
            rs_hold    <= 1'b0;
            rw_hold    <= 1'b0;
            e_cnt      <= '0;
            fall_ok    <= 1'b0;
            fall_short <= 1'b0;
            nib        <= '0;
            rs         <= 1'b0;
            rw         <= 1'b0;
        end else begin
            d_s1   <= lcd_d;
            d_s2   <= d_s1;
            e_s1   <= lcd_e;
            e_s2   <= e_s1;
            rs_s1  <= lcd_rs;
            rs_s2  <= rs_s1;
            rw_s1  <= lcd_rw;
            rw_s2  <= rw_s1;
            e_prev <= e_s2;

            // Keep the pin values of the most recent E-high cycle so they are
            // still available once the falling edge has been seen.
            if (e_s2) begin
                nib_hold <= d_s2;
                rs_hold  <= rs_s2;
                rw_hold  <= rw_s2;
            end

            // Saturating E-high counter; on the falling-edge cycle it holds
            // the full high time.
            if (!e_s2) begin
                e_cnt <= '0;
            end else if (e_cnt < CNT_MIN) begin
                e_cnt <= e_cnt + 1'b1;
            end

            fall_ok    <= fall && (e_cnt >= CNT_MIN);
            fall_short <= fall && (e_cnt <  CNT_MIN);
            if (fall) begin
                nib <= nib_hold;
                rs  <= rs_hold;
                rw  <= rw_hold;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_monitor.sv
// Receiving-end monitor for the 4-bit character-LCD write interface.
// Rebuilds bytes from nibbles strobed on LCD_E falling edges, follows the
// 4-bit init sequence, tracks the DDRAM address counter, and reports
// character writes with their address.
// Ports:
//   clk, reset    system clock, asynchronous active-low reset
//   bus           LCD pins (slave modport)
//   mode_4bit     high once the 4-bit init nibble has been seen
//   byte_valid    pulse; byte_data/byte_rs hold the assembled byte
//   char_valid    pulse; char_data written at DDRAM address char_addr
//   clear_pulse   pulse on clear-display command
//   e_width_err   pulse on an E pulse shorter than MIN_E_CYCLES
//   frame_err     pulse when RS changed between the two nibbles of a byte
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int unsigned MIN_E_CYCLES = 12
) (
    input  logic          clk,
    input  logic          reset,
    lcd_bus_if.slave      bus,
    output logic          mode_4bit,
    output logic          byte_valid,
    output logic [7:0]    byte_data,
    output logic          byte_rs,
    output logic          char_valid,
    output logic [7:0]    char_data,
    output logic [6:0]    char_addr,
    output logic          clear_pulse,
    output logic          e_width_err,
    output logic          frame_err
);

    logic       fall_ok, fall_short;
    logic [3:0] nib;
    logic       rs, rw;

    lcd_pin_sync #(
        .MIN_E_CYCLES(MIN_E_CYCLES)
    ) u_pin_sync (
        .clk        (clk),
        .reset      (reset),
        .lcd_d      (bus.lcd_d),
        .lcd_e      (bus.lcd_e),
        .lcd_rs     (bus.lcd_rs),
        .lcd_rw     (bus.lcd_rw),
        .fall_ok    (fall_ok),
        .fall_short (fall_short),
        .nib        (nib),
        .rs         (rs),
        .rw         (rw)
    );

    lcd_state_t state, state_nxt;

    logic [6:0] addr, addr_nxt;
    logic [3:0] hi_nib, hi_nib_nxt;
    logic       hi_rs, hi_rs_nxt;
    logic       mode_nxt;
    logic       byte_valid_nxt;
    logic [7:0] byte_data_nxt;
    logic       byte_rs_nxt;
    logic       char_valid_nxt;
    logic [7:0] char_data_nxt;
    logic [6:0] char_addr_nxt;
    logic       clear_nxt;
    logic       werr_nxt;
    logic       ferr_nxt;
    logic [7:0] asm_byte;

    assign asm_byte = {hi_nib, nib};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        hi_nib_nxt     = hi_nib;
        hi_rs_nxt      = hi_rs;
        mode_nxt       = mode_4bit;
        byte_valid_nxt = 1'b0;
        byte_data_nxt  = byte_data;
        byte_rs_nxt    = byte_rs;
        char_valid_nxt = 1'b0;
        char_data_nxt  = char_data;
        char_addr_nxt  = char_addr;
        clear_nxt      = 1'b0;
        werr_nxt       = fall_short;
        ferr_nxt       = 1'b0;

        // Read strobes and rejected short pulses never touch the FSM.
        if (fall_ok && !rw) begin
            unique case (state)
                S_INIT: begin
                    if (nib == NIB_4BIT) begin
                        mode_nxt  = 1'b1;
                        state_nxt = S_HI;
                    end
                end
                S_HI: begin
                    hi_nib_nxt = nib;
                    hi_rs_nxt  = rs;
                    state_nxt  = S_LO;
                end
                S_LO: begin
                    if (rs != hi_rs) begin
                        // Resynchronize: this nibble becomes the new high half.
                        ferr_nxt   = 1'b1;
                        hi_nib_nxt = nib;
                        hi_rs_nxt  = rs;
                    end else begin
                        byte_valid_nxt = 1'b1;
                        byte_data_nxt  = asm_byte;
                        byte_rs_nxt    = rs;
                        state_nxt      = S_HI;
                        if (rs) begin
                            char_valid_nxt = 1'b1;
                            char_data_nxt  = asm_byte;
                            char_addr_nxt  = addr;
                            addr_nxt       = (addr == DDRAM_WRAP) ? '0 : addr + 7'd1;
                        end else if (asm_byte == CMD_CLEAR) begin
                            clear_nxt = 1'b1;
                            addr_nxt  = '0;
                        end else if (is_home(asm_byte)) begin
                            addr_nxt = '0;
                        end else if (asm_byte[CMD_DDADDR_BIT]) begin
                            addr_nxt = asm_byte[6:0];
                        end
                    end
                end
                default: state_nxt = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr        <= '0;
            hi_nib      <= '0;
            hi_rs       <= 1'b0;
            mode_4bit   <= 1'b0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            byte_rs     <= 1'b0;
            char_valid  <= 1'b0;
            char_data   <= '0;
            char_addr   <= '0;
            clear_pulse <= 1'b0;
            e_width_err <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            addr        <= addr_nxt;
            hi_nib      <= hi_nib_nxt;
            hi_rs       <= hi_rs_nxt;
            mode_4bit   <= mode_nxt;
            byte_valid  <= byte_valid_nxt;
            byte_data   <= byte_data_nxt;
            byte_rs     <= byte_rs_nxt;
            char_valid  <= char_valid_nxt;
            char_data   <= char_data_nxt;
            char_addr   <= char_addr_nxt;
            clear_pulse <= clear_nxt;
            e_width_err <= werr_nxt;
            frame_err   <= ferr_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Self-checking bench for lcd_bus_monitor: directed scenarios followed by
// random nibble traffic, compared against a transaction-level model.
module tb_lcd_bus_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_4bit, byte_valid, byte_rs, char_valid;
    logic [7:0] byte_data, char_data;
    logic [6:0] char_addr;
    logic       clear_pulse, e_width_err, frame_err;

    always #10 clk = ~clk;

    lcd_bus_if bus ();

    lcd_bus_monitor #(
        .MIN_E_CYCLES(12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .mode_4bit   (mode_4bit),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_rs     (byte_rs),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_addr   (char_addr),
        .clear_pulse (clear_pulse),
        .e_width_err (e_width_err),
        .frame_err   (frame_err)
    );

    int checks   = 0;
    int failures = 0;

    // Observed pulse counts and last-seen payloads
    int         n_bytes = 0, n_chars = 0, n_clears = 0, n_frames = 0, n_werrs = 0;
    logic [7:0] o_byte = '0, o_char = '0;
    logic       o_rs = 1'b0;
    logic [6:0] o_addr = '0;

    always @(negedge clk) begin
        if (byte_valid) begin n_bytes++; o_byte = byte_data; o_rs = byte_rs; end
        if (char_valid) begin n_chars++; o_char = char_data; o_addr = char_addr; end
        if (clear_pulse) n_clears++;
        if (frame_err)   n_frames++;
        if (e_width_err) n_werrs++;
    end

    // Reference model: HD44780-style receiver described transaction by transaction
    bit         m_inited = 0, m_have_hi = 0, m_hi_rs = 0;
    logic [3:0] m_hi = '0;
    int         m_addr = 0;
    int         e_bytes = 0, e_chars = 0, e_clears = 0, e_frames = 0, e_werrs = 0;
    logic [7:0] e_byte = '0, e_char = '0;
    logic       e_rs = 1'b0;
    logic [6:0] e_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_nib(input logic [3:0] n, input logic r, input logic w, input int unsigned width);
        logic [7:0] b;
        if (width < 12) begin
            e_werrs++;
        end else if (w) begin
            // reads are invisible to the receiver
        end else if (!m_inited) begin
            if (n == 4'h2) begin m_inited = 1; m_have_hi = 0; end
        end else if (!m_have_hi) begin
            m_hi = n; m_hi_rs = r; m_have_hi = 1;
        end else if (r != m_hi_rs) begin
            e_frames++; m_hi = n; m_hi_rs = r;
        end else begin
            b = {m_hi, n};
            m_have_hi = 0;
            e_bytes++; e_byte = b; e_rs = r;
            if (r) begin
                e_chars++; e_char = b; e_addr = 7'(m_addr);
                m_addr = (m_addr + 1) % 128;
            end else if (b == 8'h01) begin
                e_clears++; m_addr = 0;
            end else if (b == 8'h02 || b == 8'h03) begin
                m_addr = 0;
            end else if (b >= 8'h80) begin
                m_addr = int'(b) - 128;
            end
        end
    endtask

    task automatic compare_all();
        check("byte_count",  32'(n_bytes),  32'(e_bytes));
        check("byte_data",   32'(o_byte),   32'(e_byte));
        check("byte_rs",     32'(o_rs),     32'(e_rs));
        check("char_count",  32'(n_chars),  32'(e_chars));
        check("char_data",   32'(o_char),   32'(e_char));
        check("char_addr",   32'(o_addr),   32'(e_addr));
        check("clear_count", 32'(n_clears), 32'(e_clears));
        check("frame_count", 32'(n_frames), 32'(e_frames));
        check("werr_count",  32'(n_werrs),  32'(e_werrs));
        check("mode_4bit",   32'(mode_4bit), 32'(m_inited));
    endtask

    task automatic send_nib(input logic [3:0] n, input logic r, input logic w, input int unsigned width);
        model_nib(n, r, w, width);
        @(negedge clk);
        bus.lcd_d = n; bus.lcd_rs = r; bus.lcd_rw = w;
        repeat (2) @(negedge clk);
        bus.lcd_e = 1'b1;
        repeat (width) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (2) @(negedge clk);
        bus.lcd_d = $urandom_range(0, 15);
        repeat (6) @(negedge clk);
        #1;
        compare_all();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r);
        send_nib(b[7:4], r, 1'b0, 15);
        send_nib(b[3:0], r, 1'b0, 15);
    endtask

    task automatic do_init();
        send_nib(4'h3, 1'b0, 1'b0, 15);
        send_nib(4'h3, 1'b0, 1'b0, 15);
        send_nib(4'h3, 1'b0, 1'b0, 15);
        check("mode_before_4bit", 32'(mode_4bit), 32'd0);
        send_nib(4'h2, 1'b0, 1'b0, 15);
    endtask

    initial begin
        logic [3:0]  rn;
        logic        rr, rw;
        int unsigned rwid;

        reset = 1'b0;
        bus.lcd_d = '0; bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mode", 32'(mode_4bit), 32'd0);
        check("reset_outs", 32'({byte_valid, byte_data, byte_rs, char_valid, char_data, char_addr,
                                 clear_pulse, e_width_err, frame_err}), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Init sequence and function set
        do_init();
        check("mode_after_init", 32'(mode_4bit), 32'd1);
        send_byte(8'h28, 1'b0);
        check("funcset_byte", 32'(o_byte), 32'h28);
        check("funcset_nochar", 32'(n_chars), 32'd0);

        // DDRAM address set then characters
        send_byte(8'hC0, 1'b0);
        send_byte(8'h41, 1'b1);
        check("char_A_addr", 32'(o_addr), 32'h40);
        send_byte(8'h42, 1'b1);
        check("char_B_addr", 32'(o_addr), 32'h41);

        // Address wrap and clear
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b1);
        check("wrap_addr_7f", 32'(o_addr), 32'h7F);
        send_byte(8'h5B, 1'b1);
        check("wrap_addr_00", 32'(o_addr), 32'h00);
        send_byte(8'h85, 1'b0);
        send_byte(8'h01, 1'b0);
        check("clear_seen", 32'(n_clears), 32'd1);
        send_byte(8'h30, 1'b1);
        check("after_clear_addr", 32'(o_addr), 32'h00);

        // E width: boundary just below and at the minimum, then a short pulse
        send_nib(4'h4, 1'b1, 1'b0, 11);
        send_nib(4'h4, 1'b1, 1'b0, 12);
        send_nib(4'h6, 1'b1, 1'b0, 5);
        send_nib(4'h1, 1'b1, 1'b0, 15);
        check("width_byte", 32'(o_char), 32'h41);

        // RS change between nibbles
        send_nib(4'h4, 1'b1, 1'b0, 15);
        send_nib(4'h1, 1'b0, 1'b0, 15);
        send_nib(4'h3, 1'b0, 1'b0, 15);
        check("frame_recover_byte", 32'(o_byte), 32'h13);

        // Reset in the middle of a byte
        send_nib(4'h8, 1'b0, 1'b0, 15);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_mode", 32'(mode_4bit), 32'd0);
        check("midreset_outs", 32'({byte_valid, byte_data, byte_rs, char_valid, char_data, char_addr,
                                    clear_pulse, e_width_err, frame_err}), 32'd0);
        m_inited = 0; m_have_hi = 0; m_addr = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        send_nib(4'h4, 1'b0, 1'b0, 15);   // not an init nibble: ignored
        do_init();

        // Read strobe between nibbles
        send_nib(4'h8, 1'b0, 1'b0, 15);
        send_nib(4'hF, 1'b0, 1'b1, 15);
        send_nib(4'h5, 1'b0, 1'b0, 15);
        check("read_skip_byte", 32'(o_byte), 32'h85);
        send_byte(8'h61, 1'b1);
        check("read_skip_addr", 32'(o_addr), 32'h05);

        // Random traffic
        for (int i = 0; i < 250; i++) begin
            rn   = 4'($urandom_range(0, 15));
            rr   = (($urandom_range(0, 9)) < 6) ? 1'b1 : 1'b0;
            if (m_have_hi && $urandom_range(0, 9) < 8) rr = m_hi_rs;
            rw   = ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0;
            rwid = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 11) : $urandom_range(12, 18);
            send_nib(rn, rr, rw, rwid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_bus_monitor.md
Name: lcd_bus_monitor

Overview:
Receiving end of the 4-bit character-LCD write interface that lcd_ctrl drives: SF_D[11:8], LCD_E, LCD_RS and LCD_RW.
- Oversamples the pins with the system clock, captures nibbles on LCD_E falling edges, and reassembles bytes.
- Decodes clear, home and DDRAM-address commands and tracks the DDRAM address counter.
- Emits character-write events with address, so the displayed text can be checked or mirrored on-chip.
- Instantiated alongside lcd_ctrl at top level, or in the bench as a self-checking monitor.

Parameters:
MIN_E_CYCLES, 12, minimum LCD_E high time in clk cycles (240 ns at 50 MHz); shorter pulses are rejected.

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low; all state cleared while low
lcd_d  input  4  LCD data pins (SF_D[11:8])
lcd_e  input  1  LCD enable strobe
lcd_rs  input  1  register select, 1 = data, 0 = command
lcd_rw  input  1  1 = read, 0 = write
mode_4bit  output  1  high once 4-bit mode is entered
byte_valid  output  1  one-cycle pulse: byte_data/byte_rs valid
byte_data  output  8  assembled byte
byte_rs  output  1  RS of assembled byte
char_valid  output  1  one-cycle pulse: character written
char_data  output  8  character code
char_addr  output  7  DDRAM address the character was written to
clear_pulse  output  1  one-cycle pulse on clear-display command
e_width_err  output  1  one-cycle pulse: E pulse shorter than MIN_E_CYCLES
frame_err  output  1  one-cycle pulse: RS changed between nibbles of a byte

Behaviour:
Reset:
- All outputs are 0; addr = 0; FSM = S_INIT.

Input sampling:
- lcd_d, lcd_e, lcd_rs and lcd_rw each pass through a 2-flop synchronizer.
- Falling edge = synchronized E was 1 last cycle and is 0 now.
- Nibble, RS and RW are taken from the last cycle synchronized E was high.

E width check:
- A saturating counter counts synchronized-E-high cycles and clears when E is low.
- If the count is below MIN_E_CYCLES at the falling edge: e_width_err pulses and the nibble is discarded with no state change.

Reads:
- A falling edge with RW = 1 is ignored; FSM, addr and nibble phase are unchanged.

FSM:
- S_INIT:
  - Nibble 0x3: stay.
  - Nibble 0x2: set mode_4bit = 1, go to S_HI.
  - Any other nibble: ignored.
- S_HI: latch the nibble as the high nibble plus its RS; go to S_LO.
- S_LO, RS equal to the latched RS: assemble {hi, lo}, pulse byte_valid, go to S_HI.
- S_LO, RS differs from the latched RS: pulse frame_err, latch this nibble as the new high nibble, stay in S_LO.

Latency:
- byte_valid asserts on the cycle after the synchronized falling edge of the low nibble, i.e. 4 clk after raw lcd_e falls.

Byte decode (same cycle as byte_valid):
- byte_rs = 1:
  - char_valid pulses with char_data = byte and char_addr = addr.
  - addr then increments modulo 128 (0x7F wraps to 0x00).
- Command 0x01: clear_pulse pulses; addr = 0.
- Command 0x02 or 0x03 (home): addr = 0.
- Command 1xxxxxxx: addr = byte[6:0].
- All other commands: byte_valid only; no effect on addr. This includes function set, entry mode, display control and CG-RAM address.

Other rules:
- No inter-nibble timeout; the phase is held indefinitely.
- Reset asserted mid-byte discards the partial byte and returns to S_INIT with mode_4bit = 0.
- Outputs are registered; no combinational path from the pins.

Decomposition:
- Shared package lcd_pkg:
  - FSM state typedef (S_INIT, S_HI, S_LO).
  - Constants CMD_CLEAR = 8'h01, CMD_HOME = 8'h02, CMD_DDADDR_BIT = 7, DDRAM_WRAP = 7'h7F.
  - Init nibbles NIB_8BIT = 4'h3 and NIB_4BIT = 4'h2, also used by lcd_ctrl.
- One sub-module, lcd_pin_sync:
  - Contains the synchronizers, falling-edge detect and E-width counter.
  - Outputs fall_ok, fall_short, nib[3:0], rs and rw.

Test Plan:
1. Reset, then E pulses of 15 cycles with nibbles 3,3,3,2, then 0x2,0x8 with RS=0 -> mode_4bit=1 after the 0x2 init nibble; byte_valid with byte_data=0x28, byte_rs=0; no char_valid.
2. After init, command 0xC0, then data 0x41 -> char_valid with char_data=0x41, char_addr=0x40; a second data byte 0x42 gives char_addr=0x41.
3. Command 0xFF (addr=0x7F), then data 0x5A,0x5B -> char_addr 0x7F then 0x00; clear 0x01 -> clear_pulse, and the next data byte has char_addr=0x00.
4. E high for 5 cycles with a valid nibble -> e_width_err pulse, no byte_valid, and the next two good nibbles assemble correctly.
5. High nibble with RS=1, low nibble with RS=0 -> frame_err pulse, no byte_valid; the next RS=0 nibble completes a byte.
6. Reset pulsed low between the high and low nibble -> all outputs 0 immediately; subsequent nibbles are treated as init (S_INIT).
7. Nibble with RW=1 inserted between the high and low nibble -> ignored; the byte still assembles from the surrounding write nibbles.
